load_store_unit: RTL

Multi-cycle memory stage between the single-cycle MIPS datapath and a handshaked data memory.
- Takes the datapath's ALU address and store data and drives a request/grant/response memory port.
- Returns sign- or zero-extended load data on the datapath's `readdata` path.
- Holds the core with `stall` until the access completes.
- Implements byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) with alignment checking and a bus timeout.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane.sv | 41 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  localparam int DEFAULT_TIMEOUT = 256;

  // The unused encoding 2'b11 behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] raw);
    size_t result;
    result = (raw == 2'b11) ? WORD : size_t'(raw);
    return result;
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    logic result;
    case (size)
      HALF:    result = offset[0];
      WORD:    result = |offset;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: byte enables and replicated store data on the
// way out, lane selection and sign/zero extension on the way back.
module lsu_lane
  import lsu_pkg::*;
(
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_byte = mem_rdata[{offset, 3'b000} +: 8];
  assign load_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = wdata;
    load_data = mem_rdata;
    case (size)
      BYTE: begin
        mem_be    = 4'b0001 << offset;
        mem_wdata = {4{wdata[7:0]}};
        load_data = {{24{load_byte[7] & ~is_unsigned}}, load_byte};
      end
      HALF: begin
        mem_be    = offset[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata[15:0]}};
        load_data = {{16{load_half[15] & ~is_unsigned}}, load_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle memory stage: captures the datapath request, runs the
// request/grant/response handshake with a timeout, and stalls the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    state_q, state_d;
  logic          we_q, we_d;
  size_t         size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        req_misaligned;
  logic        access_done;
  logic        timeout_hit;

  lsu_lane u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .mem_rdata   (mem_rdata),
    .mem_be      (lane_be),
    .mem_wdata   (lane_wdata),
    .load_data   (lane_rdata)
  );

  assign req_misaligned = is_misaligned(decode_size(req_size), addr[1:0]);

  // A response arriving in the last allowed cycle still completes the access.
  assign access_done = (state_q == REQ && mem_gnt && (we_q || mem_rvalid)) ||
                       (state_q == WAIT && mem_rvalid);
  assign timeout_hit = (state_q == REQ || state_q == WAIT) &&
                       (cnt_q == CNT_LAST) && !access_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && !req_misaligned) begin
          we_d    = req_we;
          size_d  = decode_size(req_size);
          uns_d   = req_unsigned;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (access_done) begin
          if (!we_q) rdata_d = lane_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = DONE;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (access_done) begin
          rdata_d = lane_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = req_valid && !req_misaligned && (state_q != DONE);
    misalign  = req_valid && req_misaligned && (state_q == IDLE);
    buserr    = timeout_hit;
    mem_req   = (state_q == REQ);
    mem_we    = (state_q == REQ) && we_q;
    mem_be    = (state_q == REQ) ? lane_be : 4'b0000;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = lane_wdata;
    rdata     = rdata_q;
  end

endmodule
